// File: rtl/down_sample_mc_pkg.sv
// Shared types and helpers for the multi-channel down-sampler.
package down_sample_pkg;

    // Output selection: keep the last sample of a frame, or the frame average.
    typedef enum logic {
        DS_PICK = 1'b0,
        DS_AVG  = 1'b1
    } ds_mode_e;

    // Accumulator width: one sample plus headroom for 2^max_log2 additions.
    function automatic int acc_width(input int din_w, input int max_log2);
        return din_w + max_log2;
    endfunction

endpackage

// File: rtl/down_sample_mc_if.sv
// Sample-stream bundle of the down-sampler: input beats, controls and outputs.
interface down_sample_mc_if #(
    parameter int CH_NUM    = 2,
    parameter int DIN_WIDTH = 12,
    parameter int MAX_LOG2  = 6
);
    localparam int KW = $clog2(MAX_LOG2 + 1);

    logic [CH_NUM*DIN_WIDTH-1:0] din;
    logic                        din_valid;
    logic [KW-1:0]               ratio_log2;
    logic                        mode;
    logic                        sync_clr;
    logic [CH_NUM*DIN_WIDTH-1:0] dout;
    logic                        dout_valid;
    logic                        frame_err;

    // Sample source / result consumer side.
    modport master (
        output din, din_valid, ratio_log2, mode, sync_clr,
        input  dout, dout_valid, frame_err
    );

    // Down-sampler side.
    modport slave (
        input  din, din_valid, ratio_log2, mode, sync_clr,
        output dout, dout_valid, frame_err
    );
endinterface

// File: rtl/down_sample_mc_acc.sv
// One channel of the down-sampler: accumulates a frame, then emits either the
// last sample (PICK) or the arithmetic-shifted sum (AVG).
// Optional macro DOWN_SAMPLE_MC_ROUND_EN: round AVG results half-up instead of
// truncating toward negative infinity.
module down_sample_acc
    import down_sample_pkg::*;
#(
    parameter int DIN_WIDTH = 12,
    parameter int MAX_LOG2  = 6,
    parameter int KW        = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic signed [DIN_WIDTH-1:0] din_ch,
    input  logic                        beat,
    input  logic                        first,
    input  logic                        last,
    input  logic                        clr,
    input  ds_mode_e                    mode,
    input  logic [KW-1:0]               k,
    output logic [DIN_WIDTH-1:0]        dout_ch
);

    localparam int ACC_W = acc_width(DIN_WIDTH, MAX_LOG2);

    logic signed [ACC_W-1:0]     acc_r;
    logic [DIN_WIDTH-1:0]        dout_r;
    logic signed [ACC_W-1:0]     base_s;
    logic signed [ACC_W-1:0]     sum_s;
    logic signed [ACC_W-1:0]     rnd_s;
    logic signed [ACC_W-1:0]     avg_s;
    logic [DIN_WIDTH-1:0]        result_s;

    // Running sum; the first beat of a frame loads the sample directly so
    // back-to-back frames need no clearing bubble.
    always_comb begin
        base_s   = '0;
        sum_s    = '0;
        rnd_s    = '0;
        avg_s    = '0;
        result_s = '0;
        if (first) begin
            base_s = '0;
        end else begin
            base_s = acc_r;
        end
        sum_s = base_s + ACC_W'(din_ch);
`ifdef DOWN_SAMPLE_MC_ROUND_EN
        if (k == '0) begin
            rnd_s = '0;
        end else begin
            rnd_s = ACC_W'(1) <<< (k - KW'(1));
        end
`else
        rnd_s = '0;
`endif
        avg_s = (sum_s + rnd_s) >>> k;
        case (mode)
            DS_PICK: result_s = din_ch;
            DS_AVG:  result_s = avg_s[DIN_WIDTH-1:0];
            default: result_s = din_ch;
        endcase
    end

    // Accumulator and held output register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            acc_r  <= '0;
            dout_r <= '0;
        end else if (beat) begin
            if (last) begin
                acc_r  <= '0;
                dout_r <= result_s;
            end else begin
                acc_r  <= sum_s;
            end
        end else if (clr) begin
            acc_r <= '0;
        end else begin
            acc_r <= acc_r;
        end
    end

    assign dout_ch = dout_r;

endmodule

// File: rtl/down_sample_mc.sv
// Multi-channel power-of-two decimator. All channels share one valid strobe
// and one frame counter; each frame of 2^k valid beats yields one output beat
// one cycle after its final beat. Ratio and mode are latched per frame.
// Optional macro DOWN_SAMPLE_MC_ROUND_EN: half-up rounding in AVG mode.
module down_sample_mc
    import down_sample_pkg::*;
#(
    parameter int CH_NUM    = 2,
    parameter int DIN_WIDTH = 12,
    parameter int MAX_LOG2  = 6
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [CH_NUM*DIN_WIDTH-1:0]      din,
    input  logic                             din_valid,
    input  logic [$clog2(MAX_LOG2+1)-1:0]    ratio_log2,
    input  logic                             mode,
    input  logic                             sync_clr,
    output logic [CH_NUM*DIN_WIDTH-1:0]      dout,
    output logic                             dout_valid,
    output logic                             frame_err
);

    localparam int KW = $clog2(MAX_LOG2 + 1);
    localparam int CW = (MAX_LOG2 > 0) ? MAX_LOG2 : 1;

    logic [CW-1:0] cnt_r;
    logic [KW-1:0] k_r;
    ds_mode_e      mode_r;
    logic          dout_valid_r;
    logic          frame_err_r;

    logic          clamp_s;
    logic [KW-1:0] k_in_s;
    ds_mode_e      mode_in_s;
    logic          first_s;
    logic [KW-1:0] eff_k_s;
    ds_mode_e      eff_mode_s;
    logic [CW-1:0] idx_s;
    logic [CW:0]   ratio_s;
    logic [CW-1:0] last_idx_s;
    logic          last_s;

    // Frame control: detect frame start, pick the ratio/mode in force for
    // this beat and flag the beat that closes the frame.
    always_comb begin
        clamp_s    = 1'b0;
        k_in_s     = ratio_log2;
        mode_in_s  = ds_mode_e'(mode);
        first_s    = 1'b0;
        eff_k_s    = k_r;
        eff_mode_s = mode_r;
        idx_s      = cnt_r;
        ratio_s    = '0;
        last_idx_s = '0;
        last_s     = 1'b0;
        if (ratio_log2 > KW'(MAX_LOG2)) begin
            clamp_s = 1'b1;
            k_in_s  = KW'(MAX_LOG2);
        end else begin
            clamp_s = 1'b0;
            k_in_s  = ratio_log2;
        end
        // sync_clr restarts counting, so a beat in the same cycle opens a frame.
        first_s = din_valid && (sync_clr || (cnt_r == '0));
        if (first_s) begin
            eff_k_s    = k_in_s;
            eff_mode_s = mode_in_s;
            idx_s      = '0;
        end else begin
            eff_k_s    = k_r;
            eff_mode_s = mode_r;
            idx_s      = cnt_r;
        end
        ratio_s    = (CW+1)'(1) << eff_k_s;
        last_idx_s = CW'(ratio_s - (CW+1)'(1));
        last_s     = din_valid && (idx_s == last_idx_s);
    end

    // Frame counter, per-frame captures, output strobe and sticky clamp flag.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_r        <= '0;
            k_r          <= '0;
            mode_r       <= DS_PICK;
            dout_valid_r <= 1'b0;
            frame_err_r  <= 1'b0;
        end else begin
            dout_valid_r <= last_s;
            frame_err_r  <= frame_err_r | (first_s & clamp_s);
            if (din_valid) begin
                if (first_s) begin
                    k_r    <= k_in_s;
                    mode_r <= mode_in_s;
                end else begin
                    k_r    <= k_r;
                    mode_r <= mode_r;
                end
                if (last_s) begin
                    cnt_r <= '0;
                end else begin
                    cnt_r <= idx_s + CW'(1);
                end
            end else if (sync_clr) begin
                cnt_r <= '0;
            end else begin
                cnt_r <= cnt_r;
            end
        end
    end

    genvar g;
    generate
        for (g = 0; g < CH_NUM; g++) begin : g_ch
            down_sample_acc #(
                .DIN_WIDTH (DIN_WIDTH),
                .MAX_LOG2  (MAX_LOG2),
                .KW        (KW)
            ) u_acc (
                .clk     (clk),
                .rst_n   (rst_n),
                .din_ch  (din[g*DIN_WIDTH +: DIN_WIDTH]),
                .beat    (din_valid),
                .first   (first_s),
                .last    (last_s),
                .clr     (sync_clr),
                .mode    (eff_mode_s),
                .k       (eff_k_s),
                .dout_ch (dout[g*DIN_WIDTH +: DIN_WIDTH])
            );
        end
    endgenerate

    assign dout_valid = dout_valid_r;
    assign frame_err  = frame_err_r;

endmodule

// File: doc/down_sample_mc.md
DOWN_SAMPLE_MC -- requirements
Module: down_sample_mc

Interface
REQ-001 SHALL have parameter CH_NUM, 2, number of parallel channels sharing one valid strobe.
REQ-002 SHALL have parameter DIN_WIDTH, 12, signed two's-complement sample width per channel.
REQ-003 SHALL have parameter MAX_LOG2, 6, maximum decimation exponent; the maximum ratio is 2^MAX_LOG2.
REQ-004 SHALL have port clk  input  1  the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n  input  1  reset; synchronous and active-low.
REQ-006 SHALL have port din  input  CH_NUM*DIN_WIDTH  packed samples; channel 0 is in the LSBs.
REQ-007 SHALL have port din_valid  input  1  marks a beat of din as valid for all channels.
REQ-008 SHALL have port ratio_log2  input  $clog2(MAX_LOG2+1)  decimation exponent k, giving ratio R=2^k.
REQ-009 SHALL have port mode  input  1  selects the output type: 0=PICK, 1=AVG.
REQ-010 SHALL have port sync_clr  input  1  abandons the current frame and restarts frame counting.
REQ-011 SHALL have port dout  output  CH_NUM*DIN_WIDTH  decimated samples, packed the same way as din.
REQ-012 SHALL have port dout_valid  output  1  a one-cycle strobe for each emitted output.
REQ-013 SHALL have port frame_err  output  1  a sticky flag, set when a ratio_log2 value above MAX_LOG2 is clamped.

Function
REQ-014 SHALL form frames of R consecutive valid beats; cycles with din_valid low SHALL NOT advance the frame.
REQ-015 SHALL capture ratio_log2 and mode on the first beat of each frame and hold them for the whole frame; changes mid-frame SHALL take effect from the next frame.
REQ-016 SHALL use MAX_LOG2 when the captured ratio_log2 exceeds MAX_LOG2, and SHALL set frame_err in that case.
REQ-017 SHALL, in PICK mode, output the last sample of each frame on each channel.
REQ-018 SHALL, in AVG mode, sum all R samples per channel in a DIN_WIDTH+MAX_LOG2 signed accumulator and output sum>>>k; the result always fits in DIN_WIDTH, so no saturation is needed.
REQ-019 SHALL assert dout and dout_valid on the clock edge after the final beat of a frame (latency 1), with dout_valid high for exactly one cycle.
REQ-020 SHALL hold dout between strobes.
REQ-021 SHALL make every beat its own frame when k=0, in both modes; dout then equals din delayed by one cycle.
REQ-022 SHALL, on sync_clr, zero the frame counter and accumulators and emit nothing for the partial frame.
REQ-023 SHALL, when sync_clr and din_valid are high in the same cycle, count that beat as beat 1 of a new frame, capturing ratio_log2 and mode from that cycle.
REQ-024 SHALL, when the final beat of a frame and the first beat of the next frame fall on consecutive cycles, let the accumulators load the new sample directly; no beat is lost and there are no bubbles.

Reset
REQ-025 SHALL, while rst_n is low at a clk edge, set dout=0, dout_valid=0, frame_err=0, frame counter=0, accumulators=0, captured k=0 and captured mode=PICK.
REQ-026 SHALL, on reset mid-frame, discard the partial frame; the first valid beat after reset starts a new frame.

Configuration
REQ-027 SHALL, when DOWN_SAMPLE_MC_ROUND_EN is defined, round AVG-mode results half-up by adding 2^(k-1) before the shift (nothing is added when k=0).
REQ-028 SHALL, when DOWN_SAMPLE_MC_ROUND_EN is undefined, truncate AVG-mode results by arithmetic shift (toward negative infinity); PICK mode is unaffected either way.

Structure
REQ-029 SHALL place the ds_mode_e typedef (DS_PICK, DS_AVG) and the accumulator-width constant function in the shared package down_sample_pkg.
REQ-030 SHALL implement one channel's accumulate, pick and shift path in the sub-module down_sample_acc, instantiated CH_NUM times; the frame counter and control stay in the top.

Verification
REQ-031 SHALL cover PICK with k=3 and din_valid continuous on samples 1..16: dout=8 and then 16, each strobed one cycle after beats 8 and 16.
REQ-032 SHALL cover AVG with k=2 on samples 1,2,3,4 and -1,-2,-3,-4: without the macro, outputs are 2 and -3; with DOWN_SAMPLE_MC_ROUND_EN, outputs are 3 and -2.
REQ-033 SHALL cover k=2 with din_valid toggling 1,0,1,0...: exactly one strobe per 4 valid beats, and idle cycles do not count.
REQ-034 SHALL cover changing ratio_log2 from 2 to 1 on beat 2 of a frame: that frame still spans 4 beats and the next spans 2.
REQ-035 SHALL cover ratio_log2=7 with MAX_LOG2=6: frames of 64 beats and frame_err=1, then rst_n low for one cycle clears frame_err and dout.
REQ-036 SHALL cover sync_clr at beat 3 of k=2, together with din_valid: there is no strobe for the old frame, and the next strobe follows 3 more beats.
